// File: rtl/branch_target_buffer_pkg.sv
// Shared machine-word width plus the BTB counter and entry types.
// Entry fields are sized for the narrowest index (ENTRIES=4), so they hold any legal configuration.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;
endpackage

package btb_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam int unsigned TAG_MAX_W = WORD_W - 4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [WORD_W-1:0]    target;
    ctr_t                 ctr;
  } btb_entry_t;
endpackage

// File: rtl/branch_target_buffer_counter.sv
// Two-bit saturating direction predictor: next state from current state and outcome.
module predict_counter
  import btb_types_pkg::*;
(
  input  ctr_t state,
  input  logic taken,
  output ctr_t next
);
  always_comb begin
    next = state;
    unique case (state)
      SNT: next = taken ? WNT : SNT;
      WNT: next = taken ? WT  : SNT;
      WT:  next = taken ? ST  : WNT;
      ST:  next = taken ? ST  : WT;
      default: next = state;
    endcase
  end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup at IF, update from MEM resolution.
// WORD_W must not exceed cpu_types_pkg::WORD_W (entry fields are sized from it).
module branch_target_buffer
  import btb_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [WORD_W-1:0] lk_target,
  input  logic              up_en,
  input  logic [WORD_W-1:0] up_pc,
  input  logic              up_taken,
  input  logic [WORD_W-1:0] up_target,
  input  logic              up_mispred,
  input  logic              flush_all,
  output logic [31:0]       n_updates,
  output logic [31:0]       n_mispred
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;
  localparam int unsigned PKG_W = cpu_types_pkg::WORD_W;

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_e, up_e;
  logic             up_hit;
  ctr_t             up_next;
  logic             unused_lo;

  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[WORD_W-1:IDX_W+2];
  assign up_idx    = up_pc[IDX_W+1:2];
  assign up_tag    = up_pc[WORD_W-1:IDX_W+2];
  assign unused_lo = ^{lk_pc[1:0], up_pc[1:0]};

  // Tags are compared at full stored width against the zero-extended PC tag.
  assign lk_e      = mem[lk_idx];
  assign lk_hit    = lk_e.valid && (lk_e.tag == TAG_MAX_W'(lk_tag));
  assign lk_taken  = lk_hit && lk_e.ctr[1];
  assign lk_target = lk_hit ? WORD_W'(lk_e.target) : '0;

  assign up_e   = mem[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == TAG_MAX_W'(up_tag));

  predict_counter u_ctr (
    .state (up_e.ctr),
    .taken (up_taken),
    .next  (up_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].ctr   <= WNT;
      end
      n_updates <= '0;
      n_mispred <= '0;
    end else begin
      if (up_en && (n_updates != '1))
        n_updates <= n_updates + 32'd1;
      if (up_en && up_mispred && (n_mispred != '1))
        n_mispred <= n_mispred + 32'd1;

      if (flush_all) begin
        for (int unsigned i = 0; i < ENTRIES; i++)
          mem[i].valid <= 1'b0;
      end else if (up_en) begin
        if (up_hit) begin
          mem[up_idx].ctr <= up_next;
          if (up_taken)
            mem[up_idx].target <= PKG_W'(up_target);
        end else if (up_taken) begin
          mem[up_idx].valid  <= 1'b1;
          mem[up_idx].tag    <= TAG_MAX_W'(up_tag);
          mem[up_idx].target <= PKG_W'(up_target);
          mem[up_idx].ctr    <= WT;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (ENTRIES=16, WORD_W=32): directed scenarios then random traffic.
module tb_branch_target_buffer;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lk_pc, up_pc, up_target;
  logic        up_en, up_taken, up_mispred, flush_all;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target, n_updates, n_mispred;

  int tests = 0;
  int fails = 0;

  // Reference model: a table keyed by pc/4 mod 16 holding what the last taken allocation stored.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_upd, m_mis;

  always #5 CLK = ~CLK;

  branch_target_buffer #(.ENTRIES(16), .WORD_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .lk_pc      (lk_pc),
    .lk_hit     (lk_hit),
    .lk_taken   (lk_taken),
    .lk_target  (lk_target),
    .up_en      (up_en),
    .up_pc      (up_pc),
    .up_taken   (up_taken),
    .up_target  (up_target),
    .up_mispred (up_mispred),
    .flush_all  (flush_all),
    .n_updates  (n_updates),
    .n_mispred  (n_mispred)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_model();
    int unsigned idx;
    logic [31:0] tag;
    bit          hit;
    idx = (lk_pc / 4) % 16;
    tag = lk_pc / 64;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    chk("lk_hit",    {31'b0, lk_hit},   {31'b0, hit});
    chk("lk_taken",  {31'b0, lk_taken}, {31'b0, hit && (m_ctr[idx] >= 2)});
    chk("lk_target", lk_target, hit ? m_tgt[idx] : 32'h0);
    chk("n_updates", n_updates, m_upd);
    chk("n_mispred", n_mispred, m_mis);
  endtask

  task automatic model_edge();
    int unsigned idx;
    logic [31:0] tag;
    idx = (up_pc / 4) % 16;
    tag = up_pc / 64;
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_upd = 0;
      m_mis = 0;
    end else begin
      if (up_en && m_upd != 32'hFFFF_FFFF) m_upd++;
      if (up_en && up_mispred && m_mis != 32'hFFFF_FFFF) m_mis++;
      if (flush_all) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
      end else if (up_en) begin
        if (m_valid[idx] && m_tag[idx] == tag) begin
          m_ctr[idx] = up_taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
          if (up_taken) m_tgt[idx] = up_target;
        end else if (up_taken) begin
          m_valid[idx] = 1;
          m_tag[idx]   = tag;
          m_tgt[idx]   = up_target;
          m_ctr[idx]   = 2;
        end
      end
    end
  endtask

  // Called at posedge+1 with inputs set; checks before the next edge, then advances the model.
  task automatic cycle();
    #4;
    check_model();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic expect_now(input string name, input bit h, input bit t, input logic [31:0] tg);
    #2;
    chk({name, "_hit"},    {31'b0, lk_hit},   {31'b0, h});
    chk({name, "_taken"},  {31'b0, lk_taken}, {31'b0, t});
    chk({name, "_target"}, lk_target, tg);
  endtask

  task automatic idle();
    RST = 0; up_en = 0; flush_all = 0; up_taken = 0; up_mispred = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit mis);
    up_en = 1; up_pc = pc; up_taken = taken; up_target = tgt; up_mispred = mis;
  endtask

  initial begin
    RST = 1; up_en = 0; flush_all = 0; up_taken = 0; up_mispred = 0;
    up_pc = '0; up_target = '0; lk_pc = 32'h40;
    @(posedge CLK);
    model_edge();
    #1;
    idle();

    // Reset state
    lk_pc = 32'h40;
    expect_now("rst", 0, 0, 32'h0);
    chk("rst_n_updates", n_updates, 32'h0);
    cycle();

    // Allocate on taken miss, then hit next cycle
    upd(32'h40, 1, 32'h100, 0);
    cycle();
    idle();
    expect_now("alloc", 1, 1, 32'h100);
    cycle();

    // Not-taken training WT -> WNT -> SNT, then saturate
    upd(32'h40, 0, 32'h0, 1); cycle();
    upd(32'h40, 0, 32'h0, 0); cycle();
    idle();
    expect_now("snt", 1, 0, 32'h100);
    cycle();
    upd(32'h40, 0, 32'h0, 1); cycle();
    idle();
    expect_now("snt_sat", 1, 0, 32'h100);
    cycle();

    // Same index, different tag replaces the entry
    upd(32'h80, 1, 32'h300, 0); cycle();
    idle();
    lk_pc = 32'h40;
    expect_now("evict_old", 0, 0, 32'h0);
    cycle();
    lk_pc = 32'h80;
    expect_now("evict_new", 1, 1, 32'h300);
    cycle();

    // Same-cycle lookup sees pre-update contents
    lk_pc = 32'h40;
    upd(32'h40, 1, 32'h400, 0);
    expect_now("same_old", 0, 0, 32'h0);
    cycle();
    idle();
    expect_now("same_new", 1, 1, 32'h400);
    cycle();

    // Flush wins over simultaneous update; update still counted
    upd(32'hC4, 1, 32'h500, 1);
    flush_all = 1;
    cycle();
    idle();
    lk_pc = 32'hC4;
    expect_now("flush_c4", 0, 0, 32'h0);
    cycle();
    lk_pc = 32'h40;
    expect_now("flush_40", 0, 0, 32'h0);
    cycle();

    // Reset in the middle of an update stream
    upd(32'h104, 1, 32'h600, 1); cycle();
    upd(32'h108, 1, 32'h604, 0); cycle();
    RST = 1;
    upd(32'h10C, 1, 32'h608, 1); cycle();
    upd(32'h110, 1, 32'h60C, 0); cycle();
    upd(32'h104, 1, 32'h610, 0); cycle();
    idle();
    chk("rstmid_n_updates", n_updates, 32'h0);
    chk("rstmid_n_mispred", n_mispred, 32'h0);
    for (int i = 0; i < 16; i++) begin
      lk_pc = 32'h100 + 32'(i * 4);
      cycle();
    end

    // Random traffic over a few tags per index
    for (int n = 0; n < 400; n++) begin
      idle();
      RST       = ($urandom_range(63) == 0);
      flush_all = ($urandom_range(31) == 0);
      up_en     = ($urandom_range(2) != 0);
      up_pc     = ($urandom_range(3) << 6) | ($urandom_range(15) << 2) | $urandom_range(3);
      up_taken  = $urandom_range(1);
      up_target = $urandom;
      up_mispred = $urandom_range(1);
      lk_pc     = ($urandom_range(3) << 6) | ($urandom_range(15) << 2) | $urandom_range(3);
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries (power of 2, 4..256).
REQ-002 SHALL have parameter WORD_W, default 32, address/instruction width.
REQ-003 SHALL use one clock CLK; reset RST is synchronous and active-high.
REQ-004 SHALL have port: CLK  in  1  clock.
REQ-005 SHALL have port: RST  in  1  synchronous active-high reset.
REQ-006 SHALL have port: lk_pc  in  WORD_W  IF-stage PC to look up.
REQ-007 SHALL have port: lk_hit  out  1  valid entry with matching tag.
REQ-008 SHALL have port: lk_taken  out  1  lk_hit AND counter in WT/ST.
REQ-009 SHALL have port: lk_target  out  WORD_W  stored target; 0 when lk_hit=0.
REQ-010 SHALL have port: up_en  in  1  resolved-branch update strobe.
REQ-011 SHALL have port: up_pc  in  WORD_W  PC of resolved branch.
REQ-012 SHALL have port: up_taken  in  1  actual branch outcome.
REQ-013 SHALL have port: up_target  in  WORD_W  actual branch target.
REQ-014 SHALL have port: up_mispred  in  1  pipeline mispredicted this branch (counted only).
REQ-015 SHALL have port: flush_all  in  1  invalidate every entry.
REQ-016 SHALL have port: n_updates  out  32  count of accepted updates.
REQ-017 SHALL have port: n_mispred  out  32  count of updates with up_mispred=1.

Function
REQ-018 SHALL index with pc[IDX_W+1:2], IDX_W=log2(ENTRIES); tag = pc[WORD_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-019 SHALL compute lookup combinationally from lk_pc and current array state (zero latency, IF-stage same cycle).
REQ-020 SHALL store per entry: valid, tag, target, 2-bit counter (SNT=0, WNT=1, WT=2, ST=3).
REQ-021 On up_en with tag hit: SHALL update target to up_target if up_taken; SHALL increment counter on taken, decrement on not-taken, saturating at ST/SNT.
REQ-022 On up_en with miss and up_taken=1: SHALL allocate/replace entry (valid=1, new tag, target, counter=WT).
REQ-023 On up_en with miss and up_taken=0: SHALL leave array unchanged.
REQ-024 Updates SHALL take effect at next CLK edge; same-cycle lookup of the updated index returns pre-update contents.
REQ-025 flush_all SHALL clear all valid bits at next edge and take priority over a simultaneous up_en (update dropped, counters still incremented).
REQ-026 n_updates SHALL increment on every up_en; n_mispred on up_en AND up_mispred; both saturate at 32'hFFFF_FFFF.
REQ-027 Tag/target/counter contents of invalid entries SHALL be don't-care; only valid gates hits.

Reset
REQ-028 RST SHALL clear all valid bits, set all counters to WNT, zero n_updates and n_mispred at next edge.
REQ-029 While RST=1, lk_hit, lk_taken SHALL be 0 and lk_target 0 from the following cycle; up_en and flush_all ignored.
REQ-030 Reset mid-operation SHALL discard any concurrent update without partial array writes.

Structure
REQ-031 Counter enum (SNT/WNT/WT/ST) and entry struct SHALL live in shared package btb_types_pkg; widths derived from cpu_types_pkg WORD_W.
REQ-032 Saturating 2-bit counter next-state logic SHALL be a sub-module predict_counter (state, taken -> next state).
REQ-033 Arrays SHALL be flops (no SRAM macro); datapath instantiates it at IF, update driven from MEM branch resolution.

Verification
REQ-034 After reset, lk_pc=0x0000_0040 -> lk_hit=0, lk_taken=0, lk_target=0; n_updates=0.
REQ-035 up_en, up_pc=0x40, up_taken=1, up_target=0x100; next cycle lk_pc=0x40 -> lk_hit=1, lk_taken=1, lk_target=0x100.
REQ-036 Two not-taken updates to 0x40 after REQ-035 -> counter WT->WNT->SNT; lk_hit=1, lk_taken=0; third not-taken stays SNT.
REQ-037 ENTRIES=16: allocate 0x40 then taken update 0x80 (same index, new tag) -> lookup 0x40 misses, 0x80 hits target.
REQ-038 Same-cycle up_en to 0x40 and lk_pc=0x40 -> old result that cycle, new result next cycle; flush_all with up_en -> all misses, n_updates+1.
REQ-039 Assert RST during up_en stream of 5 updates (2 mispred) -> counters 0, all lookups miss after release.
